clip_controller: RTL and testbench

//  Parametrised playback/record sequencer for NUM_CLIPS clip memories. It runs
//  the timer, the serializer (play), the deserializer (record) and a one-hot

---
 rtl/clip_ctrl_pkg.sv | 15 +
 rtl/clip_controller_edge_detect.sv | 21 ++
 rtl/clip_controller.sv | 149 ++++++++++++++
 tb/tb_clip_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/clip_ctrl_pkg.sv
// Shared types and defaults for the clip playback/record sequencer.
package clip_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM_PLAY,
      ARM_REC,
      PLAYING,
      RECORDING,
      DONE
   } clip_ctrl_state_t;

   localparam int LED_WIDTH_DEF = 4;

endpackage

// File: rtl/clip_controller_edge_detect.sv
// Rising-edge detector: a registered history of each command level.
// An edge is a high sample whose previous sample was low.
module command_edge_detect #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= '0;
      else     prev <= level;
   end

   assign rise = level & ~prev;

endmodule

// File: rtl/clip_controller.sv
// Play/record sequencer for NUM_CLIPS clip banks: drives timer, serdes and
// one-hot bank enables from edge-detected user commands.
module clip_controller
   import clip_ctrl_pkg::*;
#(
   parameter int NUM_CLIPS = 4,
   parameter int SEL_WIDTH = $clog2(NUM_CLIPS),
   parameter int LED_WIDTH = LED_WIDTH_DEF
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic                 play_command_i,
   input  logic                 record_command_i,
   input  logic                 stop_command_i,
   input  logic [SEL_WIDTH-1:0] play_clip_select_i,
   input  logic [SEL_WIDTH-1:0] record_clip_select_i,
   output logic                 playing_o,
   output logic                 recording_o,
   output logic [LED_WIDTH-1:0] play_clip_o,
   output logic [LED_WIDTH-1:0] record_clip_o,
   output logic [SEL_WIDTH-1:0] active_clip_o,
   output logic [NUM_CLIPS-1:0] clip_valid_o,
   output logic                 error_o,
   input  logic                 timer_done_i,
   output logic                 timer_enable_o,
   output logic                 timer_clear_o,
   output logic                 serializer_enable_o,
   output logic                 deserializer_enable_o,
   output logic                 memory_rw_o,
   output logic [NUM_CLIPS-1:0] memory_enable_o
);

   clip_ctrl_state_t state;
   logic [2:0]       rise;
   logic             play_rise, record_rise, stop_rise;

   command_edge_detect #(.WIDTH(3)) u_edge (
      .clk   (clock_i),
      .rst   (reset_i),
      .level ({stop_command_i, record_command_i, play_command_i}),
      .rise  (rise)
   );

   assign play_rise   = rise[0];
   assign record_rise = rise[1];
   assign stop_rise   = rise[2];

   // LEDs show 1-based clip numbers and track the selects directly.
   assign play_clip_o   = LED_WIDTH'(play_clip_select_i) + LED_WIDTH'(1);
   assign record_clip_o = LED_WIDTH'(record_clip_select_i) + LED_WIDTH'(1);

   function automatic logic [NUM_CLIPS-1:0] onehot(input logic [SEL_WIDTH-1:0] sel);
      onehot      = '0;
      onehot[sel] = 1'b1;
   endfunction

   // Outputs are registered from the state being entered; pulses and enables
   // default low each cycle and are re-asserted while a state holds.
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state                 <= IDLE;
         active_clip_o         <= '0;
         clip_valid_o          <= '0;
         playing_o             <= 1'b0;
         recording_o           <= 1'b0;
         error_o               <= 1'b0;
         timer_enable_o        <= 1'b0;
         timer_clear_o         <= 1'b0;
         serializer_enable_o   <= 1'b0;
         deserializer_enable_o <= 1'b0;
         memory_rw_o           <= 1'b0;
         memory_enable_o       <= '0;
      end else begin
         playing_o             <= 1'b0;
         recording_o           <= 1'b0;
         error_o               <= 1'b0;
         timer_enable_o        <= 1'b0;
         timer_clear_o         <= 1'b0;
         serializer_enable_o   <= 1'b0;
         deserializer_enable_o <= 1'b0;
         memory_rw_o           <= 1'b0;
         memory_enable_o       <= '0;
         case (state)
            IDLE: begin
               if (play_rise && !record_rise) begin
                  if (clip_valid_o[play_clip_select_i]) begin
                     state           <= ARM_PLAY;
                     active_clip_o   <= play_clip_select_i;
                     timer_clear_o   <= 1'b1;
                     memory_enable_o <= onehot(play_clip_select_i);
                  end else begin
                     error_o <= 1'b1;
                  end
               end else if (record_rise && !play_rise) begin
                  state           <= ARM_REC;
                  active_clip_o   <= record_clip_select_i;
                  timer_clear_o   <= 1'b1;
                  memory_rw_o     <= 1'b1;
                  memory_enable_o <= onehot(record_clip_select_i);
               end
            end
            ARM_PLAY: begin
               state               <= PLAYING;
               playing_o           <= 1'b1;
               timer_enable_o      <= 1'b1;
               serializer_enable_o <= 1'b1;
               memory_enable_o     <= onehot(active_clip_o);
            end
            ARM_REC: begin
               state                 <= RECORDING;
               recording_o           <= 1'b1;
               timer_enable_o        <= 1'b1;
               deserializer_enable_o <= 1'b1;
               memory_rw_o           <= 1'b1;
               memory_enable_o       <= onehot(active_clip_o);
            end
            PLAYING: begin
               if (timer_done_i || stop_rise) begin
                  state <= DONE;
               end else begin
                  playing_o           <= 1'b1;
                  timer_enable_o      <= 1'b1;
                  serializer_enable_o <= 1'b1;
                  memory_enable_o     <= onehot(active_clip_o);
               end
            end
            RECORDING: begin
               // Completion wins over a coincident abort.
               if (timer_done_i) begin
                  clip_valid_o[active_clip_o] <= 1'b1;
                  state                       <= DONE;
               end else if (stop_rise) begin
                  clip_valid_o[active_clip_o] <= 1'b0;
                  state                       <= DONE;
               end else begin
                  recording_o           <= 1'b1;
                  timer_enable_o        <= 1'b1;
                  deserializer_enable_o <= 1'b1;
                  memory_rw_o           <= 1'b1;
                  memory_enable_o       <= onehot(active_clip_o);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clip_controller.sv
// Self-checking bench for clip_controller (NUM_CLIPS=4): vector table,
// directed corner sequences and randomized traffic against a reference model.
module tb_clip_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       play = 1'b0, rec = 1'b0, stop = 1'b0, tdone = 1'b0;
   logic [1:0] psel = '0, rsel = '0;

   logic       playing_o, recording_o, error_o, timer_enable_o, timer_clear_o;
   logic       serializer_enable_o, deserializer_enable_o, memory_rw_o;
   logic [3:0] play_clip_o, record_clip_o, clip_valid_o, memory_enable_o;
   logic [1:0] active_clip_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   clip_controller #(.NUM_CLIPS(4), .LED_WIDTH(4)) dut (
      .clock_i               (clk),
      .reset_i               (rst),
      .play_command_i        (play),
      .record_command_i      (rec),
      .stop_command_i        (stop),
      .play_clip_select_i    (psel),
      .record_clip_select_i  (rsel),
      .playing_o             (playing_o),
      .recording_o           (recording_o),
      .play_clip_o           (play_clip_o),
      .record_clip_o         (record_clip_o),
      .active_clip_o         (active_clip_o),
      .clip_valid_o          (clip_valid_o),
      .error_o               (error_o),
      .timer_done_i          (tdone),
      .timer_enable_o        (timer_enable_o),
      .timer_clear_o         (timer_clear_o),
      .serializer_enable_o   (serializer_enable_o),
      .deserializer_enable_o (deserializer_enable_o),
      .memory_rw_o           (memory_rw_o),
      .memory_enable_o       (memory_enable_o)
   );

   // Reference model: phase 0 idle, 1 arming, 2 running, 3 wind-down.
   int         m_phase;
   bit         m_rec, m_err;
   int         m_clip;
   logic [3:0] m_val;
   bit         m_pp, m_rp, m_sp;

   task automatic model_reset();
      m_phase = 0; m_rec = 0; m_err = 0; m_clip = 0; m_val = '0;
      m_pp = 0; m_rp = 0; m_sp = 0;
   endtask

   task automatic model_tick();
      bit pe, re, se;
      pe = play && !m_pp;
      re = rec && !m_rp;
      se = stop && !m_sp;
      m_err = 0;
      case (m_phase)
         0: begin
            if (pe && !re) begin
               if (m_val[psel]) begin m_phase = 1; m_rec = 0; m_clip = int'(psel); end
               else m_err = 1;
            end else if (re && !pe) begin
               m_phase = 1; m_rec = 1; m_clip = int'(rsel);
            end
         end
         1: m_phase = 2;
         2: if (tdone || se) begin
               if (m_rec) m_val[m_clip] = tdone;
               m_phase = 3;
            end
         default: m_phase = 0;
      endcase
      m_pp = play; m_rp = rec; m_sp = stop;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      bit busy;
      busy = (m_phase == 1 || m_phase == 2);
      chk("playing",     32'(playing_o),             32'(m_phase == 2 && !m_rec));
      chk("recording",   32'(recording_o),           32'(m_phase == 2 && m_rec));
      chk("timer_clear", 32'(timer_clear_o),         32'(m_phase == 1));
      chk("timer_en",    32'(timer_enable_o),        32'(m_phase == 2));
      chk("ser_en",      32'(serializer_enable_o),   32'(m_phase == 2 && !m_rec));
      chk("deser_en",    32'(deserializer_enable_o), 32'(m_phase == 2 && m_rec));
      chk("mem_rw",      32'(memory_rw_o),           32'(busy && m_rec));
      chk("mem_en",      32'(memory_enable_o),       busy ? (32'd1 << m_clip) : 32'd0);
      chk("active_clip", 32'(active_clip_o),         32'(m_clip));
      chk("clip_valid",  32'(clip_valid_o),          32'(m_val));
      chk("error",       32'(error_o),               32'(m_err));
      chk("play_led",    32'(play_clip_o),           32'(psel) + 1);
      chk("rec_led",     32'(record_clip_o),         32'(rsel) + 1);
   endtask

   // Inputs change 1 time unit after the edge; outputs are checked there too.
   task automatic step();
      @(posedge clk); #1;
      model_tick();
      check_all();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_outs"}, 32'({playing_o, recording_o, error_o, timer_enable_o, timer_clear_o,
                               serializer_enable_o, deserializer_enable_o, memory_rw_o}), 32'd0);
      chk({tag, "_men"},   32'(memory_enable_o), 32'd0);
      chk({tag, "_valid"}, 32'(clip_valid_o),    32'd0);
      chk({tag, "_clip"},  32'(active_clip_o),   32'd0);
   endtask

   typedef struct {
      bit         p, r, s, td;
      logic [1:0] ps, rs;
      bit         e_play, e_rec, e_clr, e_ten, e_rw, e_err;
      logic [3:0] e_men, e_val;
   } vec_t;

   function automatic vec_t mk(bit p, bit r, bit s, bit td, logic [1:0] ps, logic [1:0] rs,
                               bit e_play, bit e_rec, bit e_clr, bit e_ten, bit e_rw, bit e_err,
                               logic [3:0] e_men, logic [3:0] e_val);
      vec_t v;
      v.p = p; v.r = r; v.s = s; v.td = td; v.ps = ps; v.rs = rs;
      v.e_play = e_play; v.e_rec = e_rec; v.e_clr = e_clr; v.e_ten = e_ten;
      v.e_rw = e_rw; v.e_err = e_err; v.e_men = e_men; v.e_val = e_val;
      return v;
   endfunction

   vec_t tbl[14];
   int   n_clr;

   initial begin
      //            p r s td ps rs  ply rec clr ten rw err men      val
      tbl[0]  = mk(0,1,0,0, 0, 1,  0,  0,  1,  0,  1, 0, 4'b0010, 4'b0000); // arm record clip 1
      tbl[1]  = mk(0,1,0,0, 0, 1,  0,  1,  0,  1,  1, 0, 4'b0010, 4'b0000);
      tbl[2]  = mk(0,0,0,0, 0, 1,  0,  1,  0,  1,  1, 0, 4'b0010, 4'b0000);
      tbl[3]  = mk(0,0,0,1, 0, 1,  0,  0,  0,  0,  0, 0, 4'b0000, 4'b0010); // timer done
      tbl[4]  = mk(0,0,0,0, 0, 1,  0,  0,  0,  0,  0, 0, 4'b0000, 4'b0010);
      tbl[5]  = mk(1,0,0,0, 3, 1,  0,  0,  0,  0,  0, 1, 4'b0000, 4'b0010); // empty clip 3
      tbl[6]  = mk(0,0,0,0, 3, 1,  0,  0,  0,  0,  0, 0, 4'b0000, 4'b0010);
      tbl[7]  = mk(1,0,0,0, 1, 0,  0,  0,  1,  0,  0, 0, 4'b0010, 4'b0010); // play clip 1
      tbl[8]  = mk(1,0,0,0, 1, 0,  1,  0,  0,  1,  0, 0, 4'b0010, 4'b0010);
      tbl[9]  = mk(0,0,1,0, 1, 0,  0,  0,  0,  0,  0, 0, 4'b0000, 4'b0010); // stop
      tbl[10] = mk(0,0,0,0, 1, 0,  0,  0,  0,  0,  0, 0, 4'b0000, 4'b0010);
      tbl[11] = mk(1,1,0,0, 1, 2,  0,  0,  0,  0,  0, 0, 4'b0000, 4'b0010); // both edges
      tbl[12] = mk(1,1,0,0, 1, 2,  0,  0,  0,  0,  0, 0, 4'b0000, 4'b0010);
      tbl[13] = mk(0,0,0,0, 0, 0,  0,  0,  0,  0,  0, 0, 4'b0000, 4'b0010);

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         play = tbl[i].p; rec = tbl[i].r; stop = tbl[i].s; tdone = tbl[i].td;
         psel = tbl[i].ps; rsel = tbl[i].rs;
         step();
         chk($sformatf("vec%0d_play", i),  32'(playing_o),       32'(tbl[i].e_play));
         chk($sformatf("vec%0d_rec", i),   32'(recording_o),     32'(tbl[i].e_rec));
         chk($sformatf("vec%0d_clr", i),   32'(timer_clear_o),   32'(tbl[i].e_clr));
         chk($sformatf("vec%0d_ten", i),   32'(timer_enable_o),  32'(tbl[i].e_ten));
         chk($sformatf("vec%0d_rw", i),    32'(memory_rw_o),     32'(tbl[i].e_rw));
         chk($sformatf("vec%0d_err", i),   32'(error_o),         32'(tbl[i].e_err));
         chk($sformatf("vec%0d_men", i),   32'(memory_enable_o), 32'(tbl[i].e_men));
         chk($sformatf("vec%0d_valid", i), 32'(clip_valid_o),    32'(tbl[i].e_val));
      end

      // Play held high across three timer periods: exactly one playback.
      play = 1'b1; psel = 2'd1; n_clr = 0;
      for (int c = 0; c < 30; c++) begin
         tdone = (c % 8 == 7);
         step();
         if (timer_clear_o) n_clr++;
      end
      play = 1'b0; tdone = 1'b0;
      step(); step();
      chk("held_play_once", 32'(n_clr), 32'd1);

      // Play clip 1, stop 10 cycles into playback; recording stays valid.
      play = 1'b1; step(); play = 1'b0;
      repeat (10) step();
      chk("play_running", 32'(playing_o), 32'd1);
      stop = 1'b1; step();
      chk("play_stop_done", 32'({playing_o, serializer_enable_o, memory_enable_o}), 32'd0);
      stop = 1'b0; step(); step();
      chk("play_stop_valid", 32'(clip_valid_o), 32'b0010);

      // Abort recording of clip 1 clears its flag.
      rec = 1'b1; rsel = 2'd1; step(); rec = 1'b0;
      repeat (3) step();
      stop = 1'b1; step(); stop = 1'b0; step(); step();
      chk("rec_abort_valid", 32'(clip_valid_o), 32'b0000);

      // Stop coinciding with timer done counts as completion.
      rec = 1'b1; step(); rec = 1'b0;
      repeat (3) step();
      stop = 1'b1; tdone = 1'b1; step(); stop = 1'b0; tdone = 1'b0; step(); step();
      chk("rec_tie_valid", 32'(clip_valid_o), 32'b0010);

      // Randomized traffic against the model.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(3) == 0) play = ~play;
         if ($urandom_range(3) == 0) rec  = ~rec;
         if ($urandom_range(5) == 0) stop = ~stop;
         tdone = ($urandom_range(5) == 0);
         psel  = 2'($urandom_range(3));
         rsel  = 2'($urandom_range(3));
         step();
      end
      play = 1'b0; rec = 1'b0; stop = 1'b0; tdone = 1'b0;
      repeat (3) step();

      // Asynchronous reset in the middle of recording clip 2.
      rec = 1'b1; rsel = 2'd2; step(); rec = 1'b0; step(); step();
      chk("pre_reset_rec", 32'(recording_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_zero("async_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      step(); step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
